// File: rtl/orb_frame_reader_if.sv
// RAM read port and downstream word stream of the orbital frame reader.
// The master modport is the reader; the slave side is the RAM plus the transmitter.
interface orb_frame_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
);
  logic              RE;
  logic [ADDR_W:0]   rdAddr;
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] oWord;
  logic              oValid;
  logic              iReady;
  logic              oFirst;
  logic              oLast;

  modport master (
    output RE, rdAddr, oWord, oValid, oFirst, oLast,
    input  rdData, iReady
  );

  modport slave (
    input  RE, rdAddr, oWord, oValid, oFirst, oLast,
    output rdData, iReady
  );
endinterface

// File: rtl/orb_frame_reader.sv
// Frame read-out: swaps the bank select, streams FRAME_WORDS words of the released bank
// through a small credit-controlled show-ahead FIFO onto a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start
// SWAP  | one clk: toggle SW, clear counters, raise busy
// READ  | issuing RAM reads under credit control
// DRAIN | all reads issued, emptying the FIFO
module orb_frame_reader #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 12,
  parameter int FRAME_WORDS = 2048,
  parameter int RD_LAT      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  orb_frame_reader_if.master bus,
  output logic SW,
  output logic busy,
  output logic frameDone,
  output logic overrun
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = RD_LAT + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);
  localparam logic [3:0]       CREDITS  = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, SWAP, READ, DRAIN} state_t;

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  issueCnt, popCnt;
  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] mem [4];
  logic [1:0]        wrPtr, rdPtr;
  logic [2:0]        fifoCount;
  logic [2:0]        inflight;
  logic              rdEn, push, pop, oValidInt;

  function automatic logic [1:0] nextPtr(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 3'(vld[i]);
  end

  assign push      = vld[RD_LAT-1];
  assign oValidInt = (fifoCount != 3'd0);
  assign pop       = oValidInt & bus.iReady;

  // A word leaving the FIFO this clk frees its slot, so back-to-back streaming keeps going.
  assign rdEn = (state == READ) && (issueCnt < FULL) &&
                (({1'b0, inflight} + {1'b0, fifoCount} - 4'(pop)) < CREDITS);

  always_comb begin
    stateNxt  = state;
    frameDone = 1'b0;
    overrun   = start && (state != IDLE);
    case (state)
      IDLE:    if (start) stateNxt = SWAP;
      SWAP:    stateNxt = READ;
      READ:    if (issueCnt == FULL) stateNxt = DRAIN;
      DRAIN: begin
        if (popCnt == FULL) begin
          stateNxt  = IDLE;
          frameDone = 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SW       <= 1'b0;
      busy     <= 1'b0;
      issueCnt <= '0;
      popCnt   <= '0;
    end else if (state == SWAP) begin
      SW       <= ~SW;
      busy     <= 1'b1;
      issueCnt <= '0;
      popCnt   <= '0;
    end else begin
      if (rdEn)      issueCnt <= issueCnt + 1'b1;
      if (pop)       popCnt   <= popCnt + 1'b1;
      if (frameDone) busy     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else begin
      vld[0] <= rdEn;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= bus.rdData;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (pop) rdPtr <= nextPtr(rdPtr);
      fifoCount <= fifoCount + 3'(push) - 3'(pop);
    end
  end

  assign bus.RE     = rdEn;
  assign bus.rdAddr = rdEn ? {~SW, issueCnt[ADDR_W-1:0]} : '0;
  assign bus.oWord  = mem[rdPtr];
  assign bus.oValid = oValidInt;
  assign bus.oFirst = oValidInt && (popCnt == '0);
  assign bus.oLast  = oValidInt && (popCnt == LAST_IDX);

endmodule

// File: tb/tb_orb_frame_reader.sv
// Bench for orb_frame_reader: a 2048-word RD_LAT=1 instance and a 32-word RD_LAT=3 instance,
// each checked every cycle against a frame-level model of words, banks, flags and pulses.
module tb_orb_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic startA, startB;
  logic swA, busyA, fdA, orA;
  logic swB, busyB, fdB, orB;

  orb_frame_reader_if #(.ADDR_W(11), .DATA_W(12)) busA ();
  orb_frame_reader_if #(.ADDR_W(5),  .DATA_W(12)) busB ();

  orb_frame_reader #(.ADDR_W(11), .DATA_W(12), .FRAME_WORDS(2048), .RD_LAT(1)) dutA (
    .clk(clk), .rst(rst), .start(startA), .bus(busA),
    .SW(swA), .busy(busyA), .frameDone(fdA), .overrun(orA)
  );

  orb_frame_reader #(.ADDR_W(5), .DATA_W(12), .FRAME_WORDS(32), .RD_LAT(3)) dutB (
    .clk(clk), .rst(rst), .start(startB), .bus(busB),
    .SW(swB), .busy(busyB), .frameDone(fdB), .overrun(orB)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  const int FWv[2] = '{2048, 32};
  const int RDL[2] = '{1, 3};
  const int AW[2]  = '{11, 5};

  bit act[2];
  bit expSW[2];
  bit fullRate[2];
  bit pOv[2], pIr[2];
  int pWord[2];
  int sCyc[2], issued[2], popped[2], lastPop[2];
  int frames[2], overruns[2], maxOut[2], fdCyc[2];

  function automatic int ramVal(int id, int bank, int idx);
    return ((idx * 37) ^ (bank * 1365) ^ (id * 291) ^ ((idx >> 4) * 11)) & 'hFFF;
  endfunction

  task automatic chk(bit ok, string name, longint actual, longint expected);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // synchronous-read RAMs with 1 and 3 clk latency; garbage on the bus when not reading
  logic [11:0] pB0, pB1;
  always @(posedge clk) begin
    busA.rdData <= busA.RE ? 12'(ramVal(0, int'(busA.rdAddr[11]), int'(busA.rdAddr[10:0])))
                           : 12'($urandom);
    pB0 <= busB.RE ? 12'(ramVal(1, int'(busB.rdAddr[5]), int'(busB.rdAddr[4:0])))
                   : 12'($urandom);
    pB1 <= pB0;
    busB.rdData <= pB1;
  end

  task automatic model(int id, bit st, bit re, int addr, int word, bit ov, bit ir,
                       bit of, bit ol, bit sw, bit bsy, bit fd, bit orun);
    bit a0, fdExp;
    int bank, fw, outst;
    fw = FWv[id];
    if (!rst) begin
      chk({re, ov, of, ol, sw, bsy, fd, orun} == 8'd0 && addr == 0 && word == 0,
          $sformatf("resetState%0d", id), {re, ov, of, ol, sw, bsy, fd, orun}, 0);
      act[id] = 0; expSW[id] = 0; issued[id] = 0; popped[id] = 0;
      lastPop[id] = -10; pOv[id] = 0; pIr[id] = 0;
      return;
    end
    a0 = act[id];
    fdExp = a0 && popped[id] == fw && lastPop[id] == cyc - 1;
    chk(fd == fdExp, $sformatf("frameDone%0d", id), fd, fdExp);
    chk(orun == (st && a0), $sformatf("overrun%0d", id), orun, st && a0);
    if (st && a0) overruns[id]++;
    if (a0 && cyc == sCyc[id] + 2) expSW[id] = ~expSW[id];
    if (!(a0 && cyc == sCyc[id] + 1)) begin
      chk(sw == expSW[id], $sformatf("SW%0d", id), sw, expSW[id]);
      chk(bsy == a0, $sformatf("busy%0d", id), bsy, a0);
    end
    bank = expSW[id] ? 0 : 1;
    if (a0 && cyc == sCyc[id] + 2) chk(re == 1'b1, $sformatf("firstRE%0d", id), re, 1);
    if (re) begin
      chk(a0 && cyc >= sCyc[id] + 2 && issued[id] < fw, $sformatf("reWindow%0d", id),
          issued[id], fw);
      chk(addr == (bank << AW[id]) + issued[id], $sformatf("rdAddr%0d", id),
          addr, (bank << AW[id]) + issued[id]);
      issued[id]++;
    end
    if (pOv[id] && !pIr[id])
      chk(ov && word == pWord[id], $sformatf("stallHold%0d", id), word, pWord[id]);
    if (fullRate[id] && a0 && popped[id] > 0 && popped[id] < fw)
      chk(ov, $sformatf("noBubble%0d", id), ov, 1);
    if (ov) begin
      chk(a0 && popped[id] < fw, $sformatf("popWindow%0d", id), popped[id], fw);
      chk(word == ramVal(id, bank, popped[id]), $sformatf("oWord%0d", id),
          word, ramVal(id, bank, popped[id]));
      chk(of == (popped[id] == 0) && ol == (popped[id] == fw - 1), $sformatf("flags%0d", id),
          {of, ol}, {popped[id] == 0, popped[id] == fw - 1});
      if (ir) begin
        if (popped[id] == 0 && fullRate[id])
          chk(cyc == sCyc[id] + 3 + RDL[id], $sformatf("firstWordLat%0d", id),
              cyc - sCyc[id], 3 + RDL[id]);
        popped[id]++;
        lastPop[id] = cyc;
      end
    end
    outst = issued[id] - popped[id];
    if (outst > maxOut[id]) maxOut[id] = outst;
    chk(outst <= RDL[id] + 1, $sformatf("credit%0d", id), outst, RDL[id] + 1);
    if (fdExp) begin
      act[id] = 0;
      frames[id]++;
      fdCyc[id] = cyc;
    end
    if (st && !a0) begin
      act[id] = 1; sCyc[id] = cyc; issued[id] = 0; popped[id] = 0;
    end
    pOv[id] = ov; pIr[id] = ir; pWord[id] = word;
  endtask

  always @(negedge clk) begin
    cyc++;
    model(0, startA, busA.RE, int'(busA.rdAddr), int'(busA.oWord), busA.oValid, busA.iReady,
          busA.oFirst, busA.oLast, swA, busyA, fdA, orA);
    model(1, startB, busB.RE, int'(busB.rdAddr), int'(busB.oWord), busB.oValid, busB.iReady,
          busB.oFirst, busB.oLast, swB, busyB, fdB, orB);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitFrames(int id, int target, int limit);
    for (int i = 0; i < limit && frames[id] < target; i++) tick();
    chk(frames[id] >= target, $sformatf("frameTimeout%0d", id), frames[id], target);
  endtask

  task automatic waitPopped(int target, int limit);
    for (int i = 0; i < limit && popped[0] < target; i++) tick();
    chk(popped[0] >= target, "popTimeout", popped[0], target);
  endtask

  task automatic pulseA();
    startA = 1'b1;
    tick();
    startA = 1'b0;
  endtask

  task automatic runB(int target);
    for (int i = 0; i < 3000 && frames[1] < target; i++) begin
      busB.iReady = 1'($urandom_range(0, 1));
      startB = ($urandom_range(0, 96) == 0);
      tick();
    end
    startB = 1'b0;
    chk(frames[1] >= target, "frameTimeoutB", frames[1], target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, ov0;
    rst = 1'b0; startA = 1'b0; startB = 1'b0;
    busA.iReady = 1'b1; busB.iReady = 1'b0;
    fullRate[0] = 1; fullRate[1] = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk(swA == 1'b0 && busyA == 1'b0, "postResetIdle", {swA, busyA}, 0);

    // full-rate frame: SW 0->1, bank 0 streamed
    pulseA();
    waitFrames(0, 1, 3000);
    chk(fdCyc[0] - sCyc[0] == 2052, "frameDoneLatency", fdCyc[0] - sCyc[0], 2052);
    chk(swA == 1'b1, "swAfterFrame1", swA, 1);

    // back-to-back frames, second start in the clk after frameDone
    pulseA();
    waitFrames(0, 2, 3000);
    pulseA();
    waitFrames(0, 3, 3000);
    chk(swA == 1'b1, "swAfterBackToBack", swA, 1);

    // start mid-frame is an overrun and leaves the frame alone
    ov0 = overruns[0];
    pulseA();
    waitPopped(1000, 3000);
    pulseA();
    waitFrames(0, 4, 3000);
    chk(overruns[0] - ov0 == 1, "overrunCount", overruns[0] - ov0, 1);
    chk(swA == 1'b0, "swAfterOverrunFrame", swA, 0);

    // reset mid-frame, then a clean frame
    f = frames[0];
    pulseA();
    waitPopped(500, 3000);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk(swA == 1'b0, "swAfterAbort", swA, 0);
    chk(frames[0] == f, "noFrameDoneOnAbort", frames[0], f);
    pulseA();
    waitFrames(0, f + 1, 3000);
    chk(swA == 1'b1, "swAfterRecovery", swA, 1);

    // RD_LAT=3 instance: stall pattern, then random backpressure and stray starts
    startB = 1'b1;
    tick();
    startB = 1'b0;
    for (int i = 0; i < 50 && !busB.oValid; i++) tick();
    chk(busB.oValid, "firstWordB", busB.oValid, 1);
    busB.iReady = 1'b1; tick();
    busB.iReady = 1'b0; tick();
    busB.iReady = 1'b1; tick();
    busB.iReady = 1'b0; tick();
    repeat (50) tick();
    chk(maxOut[1] == 4, "fifoPeakB", maxOut[1], 4);
    runB(1);
    for (int k = 2; k <= 5; k++) begin
      startB = 1'b1;
      tick();
      startB = 1'b0;
      runB(k);
    end
    chk(swB == 1'b1, "swB", swB, 1);
    chk(maxOut[1] <= 4, "fifoBoundB", maxOut[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
